multi_cycle_ctrl: RTL and testbench
===================================

# multi_cycle_ctrl

Control unit for the multi-cycle CPU. It decodes the 6-bit opcode and sequences each instruction through IF/ID/EXE/MEM/WB states. It drives the datapath enables, the mux selects and the ALU controls `ALUSrcA`, `ALUSrcB` and `ALUOp[2:0]`. It sits directly upstream of the ALU and also consumes the ALU's `zero` flag and the sign bit of its result for branch resolution.

## Interface
- No parameters.
- `CLK` in 1: rising-edge clock.
- `Reset` in 1: asynchronous, active-low.
- `op` in 6: opcode from the instruction register, bits [31:26].
- `zero` in 1: ALU zero flag.
- `sign` in 1: ALU `result[31]`.
- `state` out 3: current state, for debug.
- `PCWre` out 1: PC write enable.
- `IRWre` out 1: instruction register write.
- `InsMemRW` out 1: instruction memory read, 1 = read.
- `ALUSrcA` out 1: 1 selects `sa`.
- `ALUSrcB` out 1: 1 selects the extended immediate.
- `ALUOp` out 3: ALU operation.
- `ExtSel` out 1: 1 = sign-extend, 0 = zero-extend.
- `RegWre` out 1: register-file write.
- `RegDst` out 2: destination select; 00 = $31, 01 = rt, 10 = rd.
- `WrRegDSrc` out 1: 0 = PC+4, 1 = DB bus.
- `mRD` / `mWR` out 1 each: data-memory read / write.
- `DBDataSrc` out 1: 0 = ALU result, 1 = memory.
- `PCSrc` out 2: 00 = PC+4, 01 = branch target, 10 = rs (jr), 11 = jump target.
- `halted` out 1: processor stopped.

## Operation
- **Opcodes:**
  - add 000000, sub 000001, addiu 000010
  - and 010000, andi 010001, ori 010010, xori 010011, sll 011000
  - slti 100110, slt 100111
  - sw 110000, lw 110001
  - beq 110100, bne 110101, bltz 110110
  - j 111000, jr 111001, jal 111010
  - halt 111111
- **State encodings:** sIF 000, sID 001, sEXE_R 110, sWB_R 111, sEXE_B 101, sEXE_M 010, sMEM 011, sWB_L 100.
- **State transitions:**
  - sIF→sID always.
  - From sID:
    - j, jr, jal → sIF
    - halt → stays in sID with `halted`=1
    - beq/bne/bltz → sEXE_B
    - sw/lw → sEXE_M
    - arithmetic/logic → sEXE_R
  - sEXE_R→sWB_R→sIF.
  - sEXE_B→sIF.
  - sEXE_M→sMEM.
  - sMEM: sw → sIF; lw → sWB_L.
  - sWB_L→sIF.
- **State register:** `state` is a flop. All other outputs decode combinationally from `state` and `op`.
- **Per-state outputs:**
  - Every state: `InsMemRW`=1.
  - sIF: `IRWre`=1.
  - sID:
    - j: `PCSrc`=11, `PCWre`=1.
    - jr: `PCSrc`=10, `PCWre`=1.
    - jal: `PCSrc`=11, `PCWre`=1, `RegWre`=1, `RegDst`=00, `WrRegDSrc`=0.
  - sEXE_R / sWB_R — `ALUOp` by opcode:
    - add / addiu 000
    - sub 001
    - slt / slti 010
    - sll 100
    - or / ori 101
    - and / andi 110
    - xor / xori 111
  - sEXE_R / sWB_R — selects:
    - `ALUSrcA`=1 only for sll.
    - `ALUSrcB`=1 for addiu, andi, ori, xori, slti.
    - `ExtSel`=1 for addiu and slti; 0 for the logic immediates.
  - sWB_R: `RegWre`=1, `WrRegDSrc`=1, `DBDataSrc`=0, `RegDst`=01 for immediate forms and 10 for R-type, `PCWre`=1.
  - sEXE_B: `ALUOp`=001, `ALUSrcB`=0, `ExtSel`=1, `PCWre`=1.
    - `PCSrc`=01 if beq&`zero`, bne&!`zero`, or bltz&`sign`.
    - Otherwise `PCSrc`=00.
  - sEXE_M: `ALUOp`=000, `ALUSrcB`=1, `ExtSel`=1.
  - sMEM:
    - sw: `mWR`=1, `PCWre`=1.
    - lw: `mRD`=1.
  - sWB_L: `RegWre`=1, `RegDst`=01, `WrRegDSrc`=1, `DBDataSrc`=1, `PCWre`=1.
- **Defaults:** all outputs not listed for a state are 0.

## Timing
- **Reset:**
  - While `Reset`=0: `state`=sIF.
  - Output overrides: `PCWre`=`RegWre`=`mWR`=`mRD`=`IRWre`=0 and `halted`=0; `InsMemRW`=1; all selects 0.
  - Deassertion: the first rising edge after `Reset` goes high executes sIF.
  - Reset asserted mid-instruction aborts it immediately. No write enable may be seen high in that cycle.
- **Cycles per instruction:** j/jr/jal/halt 2; beq/bne/bltz 3; R/I arithmetic 4; sw 4; lw 5.
- **PC update:** exactly one `PCWre` pulse per instruction, in its final cycle. `halt` never pulses `PCWre`.
- **Branch flags:** `zero` and `sign` are sampled combinationally in sEXE_B. They must be stable before the clock edge.
- **Halt:** sticky until `Reset`.

## Configuration
- Macro: `CTRL_ILLEGAL_TRAP_EN`.
- **Defined:** an undefined opcode in sID moves to sID-halt with `halted`=1. No enables are asserted.
- **Undefined:** an undefined opcode executes as a nop: sID→sIF with `PCWre`=1 and `PCSrc`=00.

## Test plan
- **Reset:** pulse `Reset` low mid-sWB_R → `RegWre`=0 immediately; `state`=000; next instruction starts at sIF.
- **add** (`op`=000000) → states 000,001,110,111 → sIF. `ALUOp`=000, `RegDst`=10. `RegWre`=1 and `PCWre`=1 only in cycle 4.
- **lw** (`op`=110001) → 5 cycles. `mRD`=1 in sMEM; sWB_L has `DBDataSrc`=1 and `RegDst`=01.
- **Branches:**
  - beq with `zero`=1 → `PCSrc`=01.
  - bne with `zero`=1 → `PCSrc`=00.
  - bltz with `sign`=1 → `PCSrc`=01.
  - Each branch takes 3 cycles.
- **jal** (`op`=111010) → sID asserts `RegWre`=1, `RegDst`=00, `WrRegDSrc`=0, `PCSrc`=11. Then halt (`op`=111111) → `halted`=1 and `PCWre` stays 0 for 10 cycles.
- **Illegal opcode:** `op`=001111.
  - With `CTRL_ILLEGAL_TRAP_EN` → `halted`=1.
  - Without it → 2-cycle nop with `PCSrc`=00.

Source files
------------

// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - multi-cycle CPU control FSM; optional CTRL_ILLEGAL_TRAP_EN halts on undefined opcodes
module multi_cycle_ctrl (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       sign,
    output logic [2:0] state,
    output logic       PCWre,
    output logic       IRWre,
    output logic       InsMemRW,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       ExtSel,
    output logic       RegWre,
    output logic [1:0] RegDst,
    output logic       WrRegDSrc,
    output logic       mRD,
    output logic       mWR,
    output logic       DBDataSrc,
    output logic [1:0] PCSrc,
    output logic       halted
);

    localparam logic [2:0] S_IF    = 3'b000;
    localparam logic [2:0] S_ID    = 3'b001;
    localparam logic [2:0] S_EXE_M = 3'b010;
    localparam logic [2:0] S_MEM   = 3'b011;
    localparam logic [2:0] S_WB_L  = 3'b100;
    localparam logic [2:0] S_EXE_B = 3'b101;
    localparam logic [2:0] S_EXE_R = 3'b110;
    localparam logic [2:0] S_WB_R  = 3'b111;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_AND   = 6'b010000;
    localparam logic [5:0] OP_ANDI  = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_XORI  = 6'b010011;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLTI  = 6'b100110;
    localparam logic [5:0] OP_SLT   = 6'b100111;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_BLTZ  = 6'b110110;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    logic [2:0] next_state;

    logic is_r_alu, is_i_alu, is_alu, is_branch, is_mem, is_jump, is_halt, is_legal;
    logic stop;
    logic [2:0] alu_code;

    // Opcode classification shared by the next-state and output decoders
    always_comb begin
        is_r_alu  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
                    (op == OP_SLL) || (op == OP_SLT);
        is_i_alu  = (op == OP_ADDIU) || (op == OP_ANDI) || (op == OP_ORI) ||
                    (op == OP_XORI) || (op == OP_SLTI);
        is_alu    = is_r_alu || is_i_alu;
        is_branch = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLTZ);
        is_mem    = (op == OP_SW) || (op == OP_LW);
        is_jump   = (op == OP_J) || (op == OP_JR) || (op == OP_JAL);
        is_halt   = (op == OP_HALT);
        is_legal  = is_alu || is_branch || is_mem || is_jump || is_halt;
`ifdef CTRL_ILLEGAL_TRAP_EN
        stop      = is_halt || !is_legal;
`else
        stop      = is_halt;
`endif
    end

    always_comb begin
        case (op)
            OP_ADD, OP_ADDIU: alu_code = 3'b000;
            OP_SUB:           alu_code = 3'b001;
            OP_SLT, OP_SLTI:  alu_code = 3'b010;
            OP_SLL:           alu_code = 3'b100;
            OP_ORI:           alu_code = 3'b101;
            OP_AND, OP_ANDI:  alu_code = 3'b110;
            OP_XORI:          alu_code = 3'b111;
            default:          alu_code = 3'b000;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state <= S_IF;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = S_IF;
        case (state)
            S_IF: next_state = S_ID;
            S_ID: begin
                if (stop)           next_state = S_ID;
                else if (is_branch) next_state = S_EXE_B;
                else if (is_mem)    next_state = S_EXE_M;
                else if (is_alu)    next_state = S_EXE_R;
                else                next_state = S_IF;
            end
            S_EXE_R: next_state = S_WB_R;
            S_WB_R:  next_state = S_IF;
            S_EXE_B: next_state = S_IF;
            S_EXE_M: next_state = S_MEM;
            S_MEM:   next_state = (op == OP_LW) ? S_WB_L : S_IF;
            S_WB_L:  next_state = S_IF;
            default: next_state = S_IF;
        endcase
    end

    logic       pcwre_d, irwre_d, alusrca_d, alusrcb_d, extsel_d, regwre_d;
    logic       wrregdsrc_d, mrd_d, mwr_d, dbdatasrc_d, halted_d;
    logic [2:0] aluop_d;
    logic [1:0] regdst_d, pcsrc_d;

    always_comb begin
        pcwre_d     = 1'b0;
        irwre_d     = 1'b0;
        alusrca_d   = 1'b0;
        alusrcb_d   = 1'b0;
        aluop_d     = 3'b000;
        extsel_d    = 1'b0;
        regwre_d    = 1'b0;
        regdst_d    = 2'b00;
        wrregdsrc_d = 1'b0;
        mrd_d       = 1'b0;
        mwr_d       = 1'b0;
        dbdatasrc_d = 1'b0;
        pcsrc_d     = 2'b00;
        halted_d    = 1'b0;
        case (state)
            S_IF: irwre_d = 1'b1;
            S_ID: begin
                if (stop) begin
                    halted_d = 1'b1;
                end else if (op == OP_J) begin
                    pcsrc_d = 2'b11;
                    pcwre_d = 1'b1;
                end else if (op == OP_JR) begin
                    pcsrc_d = 2'b10;
                    pcwre_d = 1'b1;
                end else if (op == OP_JAL) begin
                    pcsrc_d     = 2'b11;
                    pcwre_d     = 1'b1;
                    regwre_d    = 1'b1;
                    regdst_d    = 2'b00;
                    wrregdsrc_d = 1'b0;
                end else if (!is_legal) begin
                    // Undefined opcode retires as a nop to PC+4
                    pcwre_d = 1'b1;
                end
            end
            S_EXE_R, S_WB_R: begin
                aluop_d   = alu_code;
                alusrca_d = (op == OP_SLL);
                alusrcb_d = is_i_alu;
                extsel_d  = (op == OP_ADDIU) || (op == OP_SLTI);
                if (state == S_WB_R) begin
                    regwre_d    = 1'b1;
                    wrregdsrc_d = 1'b1;
                    regdst_d    = is_i_alu ? 2'b01 : 2'b10;
                    pcwre_d     = 1'b1;
                end
            end
            S_EXE_B: begin
                aluop_d  = 3'b001;
                extsel_d = 1'b1;
                pcwre_d  = 1'b1;
                if (((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero) ||
                    ((op == OP_BLTZ) && sign))
                    pcsrc_d = 2'b01;
            end
            S_EXE_M: begin
                aluop_d   = 3'b000;
                alusrcb_d = 1'b1;
                extsel_d  = 1'b1;
            end
            S_MEM: begin
                if (op == OP_SW) begin
                    mwr_d   = 1'b1;
                    pcwre_d = 1'b1;
                end else if (op == OP_LW) begin
                    mrd_d = 1'b1;
                end
            end
            S_WB_L: begin
                regwre_d    = 1'b1;
                regdst_d    = 2'b01;
                wrregdsrc_d = 1'b1;
                dbdatasrc_d = 1'b1;
                pcwre_d     = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset masks every enable and select combinationally so an aborted
    // instruction cannot write anything in the cycle reset is asserted.
    always_comb begin
        InsMemRW  = 1'b1;
        PCWre     = Reset & pcwre_d;
        IRWre     = Reset & irwre_d;
        ALUSrcA   = Reset & alusrca_d;
        ALUSrcB   = Reset & alusrcb_d;
        ALUOp     = Reset ? aluop_d : 3'b000;
        ExtSel    = Reset & extsel_d;
        RegWre    = Reset & regwre_d;
        RegDst    = Reset ? regdst_d : 2'b00;
        WrRegDSrc = Reset & wrregdsrc_d;
        mRD       = Reset & mrd_d;
        mWR       = Reset & mwr_d;
        DBDataSrc = Reset & dbdatasrc_d;
        PCSrc     = Reset ? pcsrc_d : 2'b00;
        halted    = Reset & halted_d;
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb/tb_multi_cycle_ctrl.sv - scoreboard bench for multi_cycle_ctrl
module tb_multi_cycle_ctrl;

    typedef struct packed {
        logic [2:0] st;
        logic       pcwre;
        logic       irwre;
        logic       insmemrw;
        logic       alusrca;
        logic       alusrcb;
        logic [2:0] aluop;
        logic       extsel;
        logic       regwre;
        logic [1:0] regdst;
        logic       wrregdsrc;
        logic       mrd;
        logic       mwr;
        logic       dbdatasrc;
        logic [1:0] pcsrc;
        logic       halted;
    } exp_t;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [5:0] op;
    logic       zero, sign;
    logic [2:0] state;
    logic       PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel, RegWre;
    logic       WrRegDSrc, mRD, mWR, DBDataSrc, halted;
    logic [2:0] ALUOp;
    logic [1:0] RegDst, PCSrc;

    multi_cycle_ctrl dut (
        .CLK(CLK), .Reset(Reset), .op(op), .zero(zero), .sign(sign),
        .state(state), .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtSel(ExtSel),
        .RegWre(RegWre), .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .mRD(mRD),
        .mWR(mWR), .DBDataSrc(DBDataSrc), .PCSrc(PCSrc), .halted(halted)
    );

    always #5 CLK = ~CLK;

    exp_t act;
    assign act = {state, PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ALUOp, ExtSel,
                  RegWre, RegDst, WrRegDSrc, mRD, mWR, DBDataSrc, PCSrc, halted};

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_on = 0;

    localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ADDIU = 6'b000010;
    localparam logic [5:0] AND_ = 6'b010000, ANDI = 6'b010001, ORI = 6'b010010;
    localparam logic [5:0] XORI = 6'b010011, SLL = 6'b011000, SLTI = 6'b100110;
    localparam logic [5:0] SLT = 6'b100111, SW = 6'b110000, LW = 6'b110001;
    localparam logic [5:0] BEQ = 6'b110100, BNE = 6'b110101, BLTZ = 6'b110110;
    localparam logic [5:0] J = 6'b111000, JR = 6'b111001, JAL = 6'b111010;
    localparam logic [5:0] HALT = 6'b111111;

    logic [5:0] legal_ops [18] = '{ADD, SUB, ADDIU, AND_, ANDI, ORI, XORI, SLL,
                                   SLTI, SLT, SW, LW, BEQ, BNE, BLTZ, J, JR, JAL};

    function automatic bit is_legal(input logic [5:0] o);
        for (int i = 0; i < 18; i++) if (legal_ops[i] == o) return 1'b1;
        return o == HALT;
    endfunction

    function automatic exp_t rec(input logic [2:0] st);
        exp_t r;
        r = '0;
        r.st = st;
        r.insmemrw = 1'b1;
        return r;
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] o);
        case (o)
            ADD, ADDIU: return 3'd0;
            SUB:        return 3'd1;
            SLT, SLTI:  return 3'd2;
            SLL:        return 3'd4;
            ORI:        return 3'd5;
            AND_, ANDI: return 3'd6;
            default:    return 3'd7;
        endcase
    endfunction

    // Expected cycle-by-cycle trace of one instruction, derived from its mnemonic
    task automatic push_instr(input logic [5:0] o, input logic z, input logic s, output int n);
        exp_t r;
        bit imm;
        r = rec(3'b000);
        r.irwre = 1'b1;
        q.push_back(r);
        imm = (o == ADDIU) || (o == ANDI) || (o == ORI) || (o == XORI) || (o == SLTI);
        if (o == J || o == JR || o == JAL) begin
            r = rec(3'b001);
            r.pcwre = 1'b1;
            r.pcsrc = (o == JR) ? 2'b10 : 2'b11;
            r.regwre = (o == JAL);
            q.push_back(r);
            n = 2;
        end else if (imm || o == ADD || o == SUB || o == AND_ || o == SLL || o == SLT) begin
            q.push_back(rec(3'b001));
            r = rec(3'b110);
            r.aluop = alu_of(o);
            r.alusrca = (o == SLL);
            r.alusrcb = imm;
            r.extsel = (o == ADDIU) || (o == SLTI);
            q.push_back(r);
            r.st = 3'b111;
            r.regwre = 1'b1;
            r.wrregdsrc = 1'b1;
            r.regdst = imm ? 2'b01 : 2'b10;
            r.pcwre = 1'b1;
            q.push_back(r);
            n = 4;
        end else if (o == BEQ || o == BNE || o == BLTZ) begin
            q.push_back(rec(3'b001));
            r = rec(3'b101);
            r.aluop = 3'b001;
            r.extsel = 1'b1;
            r.pcwre = 1'b1;
            r.pcsrc = ((o == BEQ && z) || (o == BNE && !z) || (o == BLTZ && s)) ? 2'b01 : 2'b00;
            q.push_back(r);
            n = 3;
        end else if (o == SW || o == LW) begin
            q.push_back(rec(3'b001));
            r = rec(3'b010);
            r.alusrcb = 1'b1;
            r.extsel = 1'b1;
            q.push_back(r);
            r = rec(3'b011);
            if (o == SW) begin
                r.mwr = 1'b1;
                r.pcwre = 1'b1;
                q.push_back(r);
                n = 4;
            end else begin
                r.mrd = 1'b1;
                q.push_back(r);
                r = rec(3'b100);
                r.regwre = 1'b1;
                r.regdst = 2'b01;
                r.wrregdsrc = 1'b1;
                r.dbdatasrc = 1'b1;
                r.pcwre = 1'b1;
                q.push_back(r);
                n = 5;
            end
        end else begin
            r = rec(3'b001);
            r.pcwre = 1'b1;
            q.push_back(r);
            n = 2;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic run(input logic [5:0] o, input logic z, input logic s);
        int n;
        op = o;
        zero = z;
        sign = s;
        push_instr(o, z, s, n);
        tick(n);
    endtask

    task automatic do_reset(input int cycles);
        Reset = 1'b0;
        repeat (cycles) begin
            q.push_back(rec(3'b000));
            tick(1);
        end
        Reset = 1'b1;
    endtask

    // Stuck-until-reset trace: one fetch then the decode state held with halted
    task automatic run_stop(input logic [5:0] o, input int hold);
        exp_t r;
        op = o;
        r = rec(3'b000);
        r.irwre = 1'b1;
        q.push_back(r);
        r = rec(3'b001);
        r.halted = 1'b1;
        repeat (hold) q.push_back(r);
        tick(hold + 1);
    endtask

    always @(negedge CLK) begin
        if (mon_on) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL trace_underflow actual state=%b required=queued entry", state);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL cycle_outputs t=%0t op=%b actual=%h (state %b) required=%h (state %b)",
                             $time, op, act, act.st, e, e.st);
                end
            end
        end
    end

    initial begin
        int n;
        logic [5:0] o;
        Reset = 1'b0;
        op = 6'd0;
        zero = 1'b0;
        sign = 1'b0;
        tick(1);
        mon_on = 1;
        do_reset(2);

        run(ADD, 0, 0);
        run(LW, 0, 0);
        run(BEQ, 1, 0);
        run(BNE, 1, 0);
        run(BLTZ, 0, 1);
        run(JAL, 0, 0);
`ifndef CTRL_ILLEGAL_TRAP_EN
        run(6'b001111, 0, 0);
`endif

        for (int i = 0; i < 80; i++) begin
            o = legal_ops[$urandom_range(0, 17)];
`ifndef CTRL_ILLEGAL_TRAP_EN
            if ($urandom_range(0, 7) == 0) begin
                for (int k = 0; k < 64; k++) begin
                    o = 6'($urandom_range(0, 63));
                    if (!is_legal(o)) break;
                end
            end
`endif
            run(o, 1'($urandom), 1'($urandom));
        end

        // Abort an add in its write-back cycle
        op = ADD;
        push_instr(ADD, 0, 0, n);
        void'(q.pop_back());
        tick(3);
        do_reset(1);
        run(SW, 0, 0);

        run(JAL, 0, 0);
        run_stop(HALT, 10);
        do_reset(1);
        run(ORI, 0, 0);
`ifdef CTRL_ILLEGAL_TRAP_EN
        run_stop(6'b001111, 4);
        do_reset(1);
        run(SLTI, 0, 0);
`endif

        mon_on = 0;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL trace_drain actual=%0d leftover required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
